stoplight_monitor: RTL

STOPLIGHT_MONITOR -- requirements
Module: stoplight_monitor

---
 rtl/stoplight_monitor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/stoplight_monitor.sv
// stoplight_monitor: checks a two-way stoplight for legal lamp patterns, phase order and dwell times
module stoplight_monitor #(
  parameter int DWELL_A = 11,
  parameter int DWELL_B = 4,
  parameter int DWELL_C = 7,
  parameter int DWELL_D = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ns_red,
  input  logic       ns_yellow,
  input  logic       ns_green,
  input  logic       ew_red,
  input  logic       ew_yellow,
  input  logic       ew_green,
  input  logic       clear_fault,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic       locked,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] cycle_count
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;
  localparam logic [5:0] PAT_A = 6'b001100;
  localparam logic [5:0] PAT_B = 6'b010100;
  localparam logic [5:0] PAT_C = 6'b100001;
  localparam logic [5:0] PAT_D = 6'b100010;
  state_t state, state_n;
  logic [5:0] sample;
  logic primed, legal, fault_n;
  logic [1:0] sp, phase_n;
  logic [7:0] dwell, dwell_n, cycle_n, lim;
  logic [2:0] code, code_n;
  // The sample register is bit-ordered {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  assign legal = sample == PAT_A || sample == PAT_B || sample == PAT_C || sample == PAT_D;
  assign sp = sample == PAT_B ? 2'd1 : sample == PAT_C ? 2'd2 : sample == PAT_D ? 2'd3 : 2'd0;
  assign lim = phase == 2'd0 ? 8'(DWELL_A) : phase == 2'd1 ? 8'(DWELL_B) :
               phase == 2'd2 ? 8'(DWELL_C) : 8'(DWELL_D);
  assign phase_valid = legal;
  assign locked = state == TRACK;
  // Sample stage; primed keeps the reset-cleared sample from being judged as an illegal pattern
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sample <= '0;
      primed <= 1'b0;
    end else begin
      sample <= {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
      primed <= 1'b1;
    end
  // State register with the tracking counters and the sticky fault
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      phase <= 2'd0;
      dwell <= 8'd0;
      cycle_count <= 8'd0;
      fault <= 1'b0;
      fault_code <= 3'd0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      dwell <= dwell_n;
      cycle_count <= cycle_n;
      fault <= fault_n;
      fault_code <= code_n;
    end
  // Next-state decode: phase order A->B->C->D->A is simply phase+1 in two bits
  always_comb begin
    state_n = state;
    phase_n = phase;
    dwell_n = dwell;
    cycle_n = cycle_count;
    code = 3'd0;
    if (primed)
      case (state)
        IDLE:
          if (legal) begin
            state_n = ACQUIRE;
            phase_n = sp;
          end else code = 3'd1;
        ACQUIRE:
          if (!legal) begin
            state_n = IDLE;
            code = 3'd1;
          end else if (sp == phase + 2'd1) begin
            state_n = TRACK;
            phase_n = sp;
            dwell_n = 8'd1;
          end else if (sp != phase) begin
            phase_n = sp;
            code = 3'd2;
          end
        default:
          if (!legal) begin
            state_n = IDLE;
            dwell_n = 8'd0;
            code = 3'd1;
          end else if (sp == phase) begin
            dwell_n = dwell == 8'd255 ? dwell : dwell + 8'd1;
            code = dwell == lim ? 3'd4 : 3'd0;
          end else if (sp == phase + 2'd1) begin
            phase_n = sp;
            dwell_n = 8'd1;
            code = dwell < lim ? 3'd3 : 3'd0;
            cycle_n = phase == 2'd3 ? cycle_count + 8'd1 : cycle_count;
          end else begin
            state_n = ACQUIRE;
            phase_n = sp;
            dwell_n = 8'd0;
            code = 3'd2;
          end
      endcase
    if (clear_fault) begin
      state_n = IDLE;
      dwell_n = 8'd0;
      cycle_n = cycle_count;
    end
    fault_n = clear_fault ? code != 3'd0 : fault | (code != 3'd0);
    code_n = clear_fault ? code : (!fault && code != 3'd0) ? code : fault_code;
  end
endmodule
